// File: rtl/serial_rx_framer_pkg.sv
// Shared constants, FSM state type and check-byte accumulator for the serial receive framer.
// Build option SERIAL_RX_FRAMER_CRC8_EN selects CRC-8 (poly 0x07) instead of the XOR check.
package serial_rx_framer_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DROP    = 3'd4
  } state_e;

  // Folds one byte into the running check value (MSB-first CRC-8 or plain XOR).
  function automatic logic [7:0] check_update(input logic [7:0] acc, input logic [7:0] data);
`ifdef SERIAL_RX_FRAMER_CRC8_EN
    logic [7:0] crc_v;
    crc_v = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc_v[7]) begin
        crc_v = {crc_v[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        crc_v = {crc_v[6:0], 1'b0};
      end
    end
    return crc_v;
`else
    return acc ^ data;
`endif
  endfunction

endpackage

// File: rtl/serial_rx_commit_fifo.sv
// Payload FIFO with a speculative write pointer that is either committed (made visible to
// the reader) or rolled back to the last committed position. Entries are {last, byte}.
module serial_rx_commit_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [8:0]    wr_data,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [8:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   occupancy
);

  logic [AW:0] wr_spec_r;
  logic [AW:0] wr_cmt_r;
  logic [AW:0] rd_ptr_r;
  logic [8:0]  mem_r [DEPTH];

  // Pointer registers; a rollback outranks a write so a discarded frame can never grow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_spec_r <= {(AW+1){1'b0}};
      wr_cmt_r  <= {(AW+1){1'b0}};
      rd_ptr_r  <= {(AW+1){1'b0}};
    end else begin
      if (rollback) begin
        wr_spec_r <= wr_cmt_r;
      end else if (wr_en) begin
        wr_spec_r <= wr_spec_r + 1'b1;
      end else begin
        wr_spec_r <= wr_spec_r;
      end
      if (commit) begin
        wr_cmt_r <= wr_spec_r;
      end else begin
        wr_cmt_r <= wr_cmt_r;
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array, cleared on reset so the read port shows zero before any traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 9'h000;
      end
    end else if (wr_en && !rollback) begin
      mem_r[wr_spec_r[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];
  assign rd_valid  = (rd_ptr_r != wr_cmt_r);
  assign occupancy = wr_spec_r - rd_ptr_r;

endmodule

// File: rtl/serial_rx_framer.sv
// Byte-stream receive framer: SOF/LEN/payload/check parsing with commit-or-discard buffering.
// Build option SERIAL_RX_FRAMER_CRC8_EN selects the CRC-8 check (see serial_rx_framer_pkg).
module serial_rx_framer
  import serial_rx_framer_pkg::*;
#(
  parameter int MAX_LEN        = 32,
  parameter int FIFO_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_main_200mhz,
  input  logic        reset_sys,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        err_check,
  output logic        err_len,
  output logic        err_overflow,
  output logic        err_timeout,
  output logic [15:0] frame_count
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam int             IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [8:0]     DEPTH_W   = 9'(FIFO_DEPTH);

  state_e         state_r, state_s;
  logic [8:0]     cnt_r, cnt_s;
  logic [7:0]     chk_r, chk_s;
  logic [IW-1:0]  idle_r, idle_s;
  logic [15:0]    frame_count_s;
  logic           ok_s, ec_s, el_s, eo_s, et_s;
  logic           fifo_wr_s, fifo_commit_s, fifo_rollback_s, fifo_rd_s;
  logic [8:0]     fifo_wdata_s, fifo_rdata_s;
  logic [AW:0]    occ_s;
  logic [8:0]     free_s;

  // Space check uses registered pointers only, so a same-cycle read is not credited.
  assign free_s    = DEPTH_W - 9'(occ_s);
  assign fifo_rd_s = out_valid && out_ready;
  assign out_last  = fifo_rdata_s[8];
  assign out_data  = fifo_rdata_s[7:0];

  serial_rx_commit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_main_200mhz),
    .rst       (reset_sys),
    .wr_en     (fifo_wr_s),
    .wr_data   (fifo_wdata_s),
    .commit    (fifo_commit_s),
    .rollback  (fifo_rollback_s),
    .rd_en     (fifo_rd_s),
    .rd_data   (fifo_rdata_s),
    .rd_valid  (out_valid),
    .occupancy (occ_s)
  );

  // Next-state, FIFO control and status-pulse decode.
  always_comb begin
    state_s         = state_r;
    cnt_s           = cnt_r;
    chk_s           = chk_r;
    frame_count_s   = frame_count;
    ok_s            = 1'b0;
    ec_s            = 1'b0;
    el_s            = 1'b0;
    eo_s            = 1'b0;
    et_s            = 1'b0;
    fifo_wr_s       = 1'b0;
    fifo_commit_s   = 1'b0;
    fifo_rollback_s = 1'b0;
    fifo_wdata_s    = {1'b0, rx_data};

    if (state_r == ST_IDLE || rx_valid) begin
      idle_s = {IW{1'b0}};
    end else begin
      idle_s = idle_r + 1'b1;
    end

    if (state_r != ST_IDLE && !rx_valid && idle_r == IDLE_LAST) begin
      state_s         = ST_IDLE;
      fifo_rollback_s = 1'b1;
      et_s            = 1'b1;
      idle_s          = {IW{1'b0}};
    end else if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == SOF_BYTE) begin
            state_s = ST_LEN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LEN: begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            el_s    = 1'b1;
            state_s = ST_IDLE;
          end else if ({1'b0, rx_data} > free_s) begin
            eo_s    = 1'b1;
            cnt_s   = {1'b0, rx_data} + 9'd1;
            state_s = ST_DROP;
          end else begin
            cnt_s   = {1'b0, rx_data};
            chk_s   = check_update(8'h00, rx_data);
            state_s = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          fifo_wr_s    = 1'b1;
          fifo_wdata_s = {(cnt_r == 9'd1), rx_data};
          chk_s        = check_update(chk_r, rx_data);
          cnt_s        = cnt_r - 9'd1;
          if (cnt_r == 9'd1) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          state_s = ST_IDLE;
          if (rx_data == chk_r) begin
            fifo_commit_s = 1'b1;
            ok_s          = 1'b1;
            if (frame_count != 16'hFFFF) begin
              frame_count_s = frame_count + 16'd1;
            end else begin
              frame_count_s = frame_count;
            end
          end else begin
            fifo_rollback_s = 1'b1;
            ec_s            = 1'b1;
          end
        end
        ST_DROP: begin
          cnt_s = cnt_r - 9'd1;
          if (cnt_r == 9'd1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DROP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Framer state, counters, frame counter and registered status pulses.
  always_ff @(posedge clk_main_200mhz or posedge reset_sys) begin
    if (reset_sys) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 9'd0;
      chk_r        <= 8'h00;
      idle_r       <= {IW{1'b0}};
      frame_count  <= 16'h0000;
      frame_ok     <= 1'b0;
      err_check    <= 1'b0;
      err_len      <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      chk_r        <= chk_s;
      idle_r       <= idle_s;
      frame_count  <= frame_count_s;
      frame_ok     <= ok_s;
      err_check    <= ec_s;
      err_len      <= el_s;
      err_overflow <= eo_s;
      err_timeout  <= et_s;
    end
  end

endmodule

// File: tb/tb_serial_rx_framer.sv
// Scoreboard bench for serial_rx_framer (XOR check build): stimulus pushes expected output
// bytes and status pulses into queues; a negedge monitor pops and compares.
module tb_serial_rx_framer;

  logic        clk_main_200mhz = 1'b0;
  logic        reset_sys;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        frame_ok, err_check, err_len, err_overflow, err_timeout;
  logic [15:0] frame_count;

  localparam logic [4:0] EV_OK  = 5'b10000;
  localparam logic [4:0] EV_CHK = 5'b01000;
  localparam logic [4:0] EV_LEN = 5'b00100;
  localparam logic [4:0] EV_OVF = 5'b00010;
  localparam logic [4:0] EV_TO  = 5'b00001;

  int         checks = 0;
  int         errors = 0;
  int         drained = 0;
  logic [8:0] exp_q [$];
  logic [4:0] evt_q [$];
  logic [7:0] payload_q [$];
  logic [8:0] held_r;
  logic       hold_pending = 1'b0;

  serial_rx_framer #(
    .MAX_LEN        (32),
    .FIFO_DEPTH     (64),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk_main_200mhz (clk_main_200mhz),
    .reset_sys       (reset_sys),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .frame_ok        (frame_ok),
    .err_check       (err_check),
    .err_len         (err_len),
    .err_overflow    (err_overflow),
    .err_timeout     (err_timeout),
    .frame_count     (frame_count)
  );

  always #5 clk_main_200mhz = ~clk_main_200mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_main_200mhz);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_main_200mhz);
    #1;
  endtask

  function automatic logic [7:0] xor_chk(input logic [7:0] len);
    logic [7:0] acc;
    acc = len;
    foreach (payload_q[i]) acc = acc ^ payload_q[i];
    return acc;
  endfunction

  task automatic send_frame(input logic [7:0] len, input logic [7:0] chk, input bit good);
    send_byte(8'hA5);
    send_byte(len);
    foreach (payload_q[i]) send_byte(payload_q[i]);
    send_byte(chk);
    if (good) begin
      foreach (payload_q[i])
        exp_q.push_back({(i == payload_q.size() - 1) ? 1'b1 : 1'b0, payload_q[i]});
      evt_q.push_back(EV_OK);
    end else begin
      evt_q.push_back(EV_CHK);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_main_200mhz);
      n++;
    end
    #1;
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Monitor: pulses and output bytes are compared against the scoreboard queues.
  always @(negedge clk_main_200mhz) begin
    logic [4:0] pulses;
    logic [8:0] exp;
    if (reset_sys) begin
      hold_pending = 1'b0;
    end else begin
      pulses = {frame_ok, err_check, err_len, err_overflow, err_timeout};
      if (pulses != 5'b00000) begin
        checks++;
        if (evt_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse got %b want none", pulses);
        end else begin
          exp = {4'b0000, evt_q.pop_front()};
          if (pulses != exp[4:0]) begin
            errors++;
            $display("FAIL pulse got %b want %b", pulses, exp[4:0]);
          end
        end
      end
      if (out_valid) begin
        if (hold_pending) check("hold_stable", {23'd0, out_last, out_data}, {23'd0, held_r});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h want none", {out_last, out_data});
        end else begin
          if (out_ready) begin
            exp = exp_q.pop_front();
            drained++;
          end else begin
            exp = exp_q[0];
          end
          if ({out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL out_byte got %h want %h", {out_last, out_data}, exp);
          end
        end
      end
      hold_pending = out_valid && !out_ready;
      held_r       = {out_last, out_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    bit seen;
    reset_sys = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pulses", {frame_ok, err_check, err_len, err_overflow, err_timeout}, 0);
    check("rst_frame_count", frame_count, 0);
    reset_sys = 1'b0;
    idle(2);

    // Good frame
    payload_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h03, 8'h03, 1'b1);
    idle(6);
    check("good_count", frame_count, 1);

    // Bad check byte, then a good frame
    payload_q = '{8'hAA, 8'hBB};
    send_frame(8'h02, 8'h00, 1'b0);
    idle(3);
    check("badchk_no_valid", out_valid, 0);
    payload_q = '{8'h55};
    send_frame(8'h01, 8'h54, 1'b1);
    idle(4);
    check("badchk_count", frame_count, 2);

    // Illegal lengths, then a good frame
    send_byte(8'hA5); send_byte(8'h00); evt_q.push_back(EV_LEN);
    send_byte(8'hA5); send_byte(8'h21); evt_q.push_back(EV_LEN);
    payload_q = '{8'h10, 8'h20};
    send_frame(8'h02, 8'h32, 1'b1);
    idle(5);
    check("badlen_count", frame_count, 3);

    // Overflow: fill with two 32-byte frames, third is dropped
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      payload_q.delete();
      for (int i = 0; i < 32; i++) payload_q.push_back(8'(f * 64 + i));
      send_frame(8'h20, xor_chk(8'h20), 1'b1);
    end
    idle(2);
    check("ovf_count", frame_count, 5);
    send_byte(8'hA5); send_byte(8'h20); evt_q.push_back(EV_OVF);
    for (int i = 0; i < 33; i++) send_byte(8'hA5);
    idle(3);
    check("ovf_full_valid", out_valid, 1);
    base = drained;
    out_ready = 1'b1;
    wait_drain(200);
    check("ovf_drained", drained - base, 64);
    idle(2);
    check("ovf_empty", out_valid, 0);

    // Inter-byte timeout
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    evt_q.push_back(EV_TO);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 1100) begin
      @(negedge clk_main_200mhz);
      k++;
      if (err_timeout) seen = 1'b1;
    end
    check("timeout_cycle", k, 1025);
    idle(3);
    check("timeout_empty", out_valid, 0);

    // Reset during payload
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    reset_sys = 1'b1;
    idle(2);
    check("midrst_valid", out_valid, 0);
    check("midrst_count", frame_count, 0);
    reset_sys = 1'b0;
    idle(2);
    payload_q = '{8'h7E};
    send_frame(8'h01, 8'h7F, 1'b1);
    idle(3);
    check("midrst_count_after", frame_count, 1);

    wait_drain(50);
    idle(3);
    check("events_remaining", evt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_framer.md
# serial_rx_framer

Byte-stream receive framer between the external serial receive pins (8-bit data plus valid, no backpressure) and the serial receive port of the main IP. It hunts for start-of-frame and parses length, payload and check byte. Payload is held speculatively in a commit/rollback FIFO and released downstream, with a last-byte marker, only after the check byte verifies. Bad, oversized, overflowing or stalled frames are discarded whole and reported as error pulses.

## Interface
- `MAX_LEN`, 32: maximum payload bytes per frame; legal LEN is 1..MAX_LEN.
- `FIFO_DEPTH`, 64: payload FIFO entries, power of two, ≥ MAX_LEN.
- `TIMEOUT_CYCLES`, 1024: maximum idle cycles between bytes inside a frame.
- `clk_main_200mhz`  in  1  sole clock; all logic on its rising edge.
- `reset_sys`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  rx_data valid this cycle; always accepted.
- `out_data`  out  8  payload byte to the IP.
- `out_valid`  out  1  out_data/out_last valid.
- `out_last`  out  1  final payload byte of a frame.
- `out_ready`  in  1  IP accepts the byte.
- `frame_ok`  out  1  one-cycle pulse when a frame commits.
- `err_check`  out  1  one-cycle pulse on check-byte mismatch.
- `err_len`  out  1  one-cycle pulse when LEN is 0 or greater than MAX_LEN.
- `err_overflow`  out  1  one-cycle pulse when a frame is dropped for lack of space.
- `err_timeout`  out  1  one-cycle pulse on an inter-byte timeout.
- `frame_count`  out  16  committed frames; saturates at 0xFFFF.

## Operation
**State machine:** IDLE, LEN, PAYLOAD, CHECK, DROP. Each state advances only on a cycle with rx_valid=1.

**IDLE**
- Byte 0xA5 goes to LEN.
- Any other byte is ignored.

**LEN** (the received byte is L)
- L=0 or L>MAX_LEN: pulse err_len, go to IDLE.
- Free space < L: pulse err_overflow, load a drop counter with L+1, go to DROP. Free space is FIFO_DEPTH minus the registered occupancy, measured against the speculative write pointer.
- Otherwise: latch L, seed the check register with L, go to PAYLOAD.

**PAYLOAD**
- Write {last, byte} at the speculative write pointer (wr_spec), then increment it.
- Fold the byte into the check register.
- last=1 on byte L; after byte L go to CHECK.

**CHECK**
- Byte equals the check register: committed write pointer = wr_spec, pulse frame_ok, increment frame_count, go to IDLE.
- Byte differs: wr_spec = committed write pointer (rollback), pulse err_check, go to IDLE.

**DROP**
- Consume bytes and decrement the drop counter.
- At zero go to IDLE. Nothing is written.

**Timeout**
- An idle counter clears on every rx_valid and runs in every state except IDLE.
- When it reaches TIMEOUT_CYCLES: roll back wr_spec, pulse err_timeout, go to IDLE.

**Read side**
- out_valid = (read pointer ≠ committed write pointer).
- out_data and out_last come from the entry at the read pointer.
- The read pointer advances when out_valid && out_ready.
- out_data is held stable while out_valid && !out_ready.

**Other rules**
- 0xA5 received inside a frame is ordinary data; there is no resync until the frame ends or times out.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; the extra MSB distinguishes full from empty.

## Timing
- Reset values: state IDLE; all pointers 0; out_valid 0; out_last 0; out_data 0x00; all pulses 0; frame_count 0.
- Reset mid-frame discards the frame; no error pulse is generated.
- Commit latency: check byte sampled at edge N gives out_valid=1 in the cycle after edge N.
- Throughput:
  - Output: one byte per cycle while out_ready=1.
  - Input: one byte per cycle, always.
- Simultaneous events:
  - A read and a commit in the same cycle are both honoured.
  - A read in the LEN cycle is not credited to that cycle's space check, so the check is conservative.
  - A rollback never moves the read pointer.
- Timeout fires TIMEOUT_CYCLES cycles after the last accepted byte.
- All error pulses are mutually exclusive and one cycle wide.

## Configuration
- `SERIAL_RX_FRAMER_CRC8_EN` defined:
  - The check register is CRC-8, polynomial 0x07, init 0x00, MSB-first.
  - It covers LEN and payload.
- Undefined: the check register is the XOR of LEN and all payload bytes.
- Framing, latency and ports are identical in both builds.

## Structure
- Shared package `serial_rx_framer_pkg` holds:
  - the SOF constant 0xA5;
  - the state enum;
  - the CRC-8 polynomial;
  - a function `check_update(acc, byte)`, selected by the macro.
- One sub-module, `serial_rx_commit_fifo`:
  - 9-bit-wide storage;
  - speculative and committed write pointers;
  - commit and rollback inputs;
  - occupancy output.

## Test plan
All scenarios use the XOR build.
- **Good frame:** A5 03 11 22 33 03 with out_ready=1 → out 11, 22, 33; out_last on 33; frame_ok once; frame_count=1.
- **Bad check:** A5 02 AA BB 00 → err_check; no out_valid; FIFO empty. A following good frame then passes cleanly.
- **Bad length:** A5 00 → err_len. A5 21 (MAX_LEN=32, so 33 bytes) → err_len. A following good frame passes.
- **Overflow:**
  - Hold out_ready=0 and commit two 32-byte frames, so the FIFO is full.
  - Send a third 32-byte frame → err_overflow; its 33 following bytes are swallowed.
  - Raise out_ready → exactly 64 bytes drain, with out_last on bytes 32 and 64.
- **Timeout:** A5 04 01 02, then 1024 idle cycles → err_timeout; the FIFO stays empty.
- **Reset mid-frame:** assert reset_sys during PAYLOAD → out_valid=0, frame_count=0. After release, A5 01 7E 7F delivers 7E with out_last.
